// File: rtl/vote_booth_arbiter_if.sv
// Booth-side request/response bundle shared by all booths of the arbiter.
interface vote_booth_arbiter_if #(
    parameter int NUM_BOOTHS = 4,
    parameter int ID_W       = 4,
    parameter int CAND_W     = 1
);
    logic [NUM_BOOTHS-1:0]        booth_req;
    logic [NUM_BOOTHS*ID_W-1:0]   booth_id;
    logic [NUM_BOOTHS*CAND_W-1:0] booth_cand;
    logic [NUM_BOOTHS-1:0]        booth_ack;
    logic [1:0]                   resp_status;

    modport master (
        output booth_req,
        output booth_id,
        output booth_cand,
        input  booth_ack,
        input  resp_status
    );

    modport slave (
        input  booth_req,
        input  booth_id,
        input  booth_cand,
        output booth_ack,
        output resp_status
    );
endinterface

// File: rtl/vote_booth_arbiter.sv
// Round-robin vote arbiter with ID registry and tallies.
// TALLY_SATURATE_EN: counters saturate instead of wrapping.
module vote_booth_arbiter #(
    parameter int NUM_BOOTHS = 4,
    parameter int ID_W       = 4,
    parameter int MAX_ID     = 9,
    parameter int CAND_W     = 1,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    vote_booth_arbiter_if.slave  bus,
    input  logic                 election_open,
    input  logic [CAND_W-1:0]    tally_sel,
    output logic [CNT_W-1:0]     tally_count,
    output logic [CNT_W-1:0]     total_votes,
    output logic                 busy
);
    localparam int IDX_W    = $clog2(NUM_BOOTHS);
    localparam int NUM_IDS  = 2**ID_W;
    localparam int NUM_CAND = 2**CAND_W;

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_DUP    = 2'b01;
    localparam logic [1:0] ST_BAD    = 2'b10;
    localparam logic [1:0] ST_CLOSED = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        COMMIT,
        RESP
    } state_t;

    state_t               state, state_d;
    logic [IDX_W-1:0]     rr_ptr, grant, pick;
    logic [IDX_W:0]       idx;
    logic                 found;
    logic [ID_W-1:0]      lat_id;
    logic [CAND_W-1:0]    lat_cand;
    logic [1:0]           status, status_d, resp_q;
    logic [NUM_IDS-1:0]   used;
    logic [CNT_W-1:0]     tally [NUM_CAND];

    function automatic logic [CNT_W-1:0] bump(
        input logic [CNT_W-1:0] v
    );
`ifdef TALLY_SATURATE_EN
        return (v == '1) ? v : v + 1'b1;
`else
        return v + 1'b1;
`endif
    endfunction

    // first requester at or after rr_ptr, wrapping
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_BOOTHS; i++) begin
            idx = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (idx >= (IDX_W+1)'(NUM_BOOTHS))
                idx = idx - (IDX_W+1)'(NUM_BOOTHS);
            if (!found && bus.booth_req[idx[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        status_d = ST_OK;
        if (!election_open)
            status_d = ST_CLOSED;
        else if (32'(lat_id) > MAX_ID)
            status_d = ST_BAD;
        else if (used[lat_id])
            status_d = ST_DUP;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (found) state_d = CHECK;
            CHECK:   state_d = COMMIT;
            COMMIT:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.booth_ack = '0;
        if (state == RESP)
            bus.booth_ack[grant] = 1'b1;
    end

    assign bus.resp_status = resp_q;
    assign busy            = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= '0;
            grant       <= '0;
            lat_id      <= '0;
            lat_cand    <= '0;
            status      <= ST_OK;
            resp_q      <= ST_OK;
            used        <= '0;
            total_votes <= '0;
            tally_count <= '0;
            for (int c = 0; c < NUM_CAND; c++)
                tally[c] <= '0;
        end else begin
            tally_count <= tally[tally_sel];
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant    <= pick;
                        lat_id   <= bus.booth_id[pick*ID_W +: ID_W];
                        lat_cand <= bus.booth_cand[pick*CAND_W +: CAND_W];
                    end
                end
                CHECK: status <= status_d;
                COMMIT: begin
                    resp_q <= status;
                    if (status == ST_OK) begin
                        used[lat_id]    <= 1'b1;
                        tally[lat_cand] <= bump(tally[lat_cand]);
                        total_votes     <= bump(total_votes);
                    end
                end
                RESP: begin
                    if (grant == IDX_W'(NUM_BOOTHS-1))
                        rr_ptr <= '0;
                    else
                        rr_ptr <= grant + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vote_booth_arbiter.sv
// Directed bench for vote_booth_arbiter: vector table plus
// multi-cycle sequences for arbitration, reset abort and overflow.
module tb_vote_booth_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       open1, open2;
    logic [0:0] sel1, sel2;
    logic [7:0] tc1, tot1;
    logic [1:0] tc2, tot2;
    logic       busy1, busy2;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    vote_booth_arbiter_if #(
        .NUM_BOOTHS(4), .ID_W(4), .CAND_W(1)
    ) bus1 ();
    vote_booth_arbiter_if #(
        .NUM_BOOTHS(4), .ID_W(4), .CAND_W(1)
    ) bus2 ();

    vote_booth_arbiter #(.CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1),
        .election_open(open1), .tally_sel(sel1),
        .tally_count(tc1), .total_votes(tot1), .busy(busy1)
    );

    vote_booth_arbiter #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2),
        .election_open(open2), .tally_sel(sel2),
        .tally_count(tc2), .total_votes(tot2), .busy(busy2)
    );

    typedef struct {
        int         b;
        logic [3:0] id;
        logic       c;
        logic       op;
        logic [1:0] st;
        int         t0;
        int         t1;
        int         tot;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_req(input bit w, input int b);
        if (w) bus2.booth_req[b] = 1'b0;
        else   bus1.booth_req[b] = 1'b0;
    endtask

    task automatic vote(input bit w, input int b,
                        input logic [3:0] id, input logic c,
                        input logic op,
                        output int lat, output logic [1:0] st);
        logic [3:0] ack;
        lat = -1;
        st  = 2'bxx;
        @(negedge clk);
        if (w) begin
            bus2.booth_id[b*4 +: 4] = id;
            bus2.booth_cand[b]      = c;
            open2                   = op;
            bus2.booth_req[b]       = 1'b1;
        end else begin
            bus1.booth_id[b*4 +: 4] = id;
            bus1.booth_cand[b]      = c;
            open1                   = op;
            bus1.booth_req[b]       = 1'b1;
        end
        for (int k = 1; k <= 8 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1)
                check("busy_in_txn", w ? busy2 : busy1, 1);
            ack = w ? bus2.booth_ack : bus1.booth_ack;
            if (ack != 4'b0) begin
                lat = k;
                st  = w ? bus2.resp_status : bus1.resp_status;
                check("ack_onehot", 32'(ack), 32'(1) << b);
                clr_req(w, b);
            end
        end
        if (lat < 0) clr_req(w, b);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        bus1.booth_req = '0;
        bus2.booth_req = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int         lat, n, who;
        logic [1:0] st;
        int         exp6;

        bus1.booth_req = '0; bus1.booth_id = '0; bus1.booth_cand = '0;
        bus2.booth_req = '0; bus2.booth_id = '0; bus2.booth_cand = '0;
        open1 = 1'b1; open2 = 1'b1;
        sel1 = 1'b0; sel2 = 1'b0;

        tbl[0] = '{0, 4'd3,  1'b1, 1'b1, 2'b00, 0, 1, 1};
        tbl[1] = '{2, 4'd3,  1'b0, 1'b1, 2'b01, 0, 1, 1};
        tbl[2] = '{1, 4'd12, 1'b0, 1'b1, 2'b10, 0, 1, 1};
        tbl[3] = '{1, 4'd12, 1'b0, 1'b0, 2'b11, 0, 1, 1};
        tbl[4] = '{3, 4'd9,  1'b0, 1'b1, 2'b00, 1, 1, 2};
        tbl[5] = '{1, 4'd10, 1'b1, 1'b1, 2'b10, 1, 1, 2};
        tbl[6] = '{2, 4'd0,  1'b0, 1'b0, 2'b11, 1, 1, 2};
        tbl[7] = '{2, 4'd0,  1'b0, 1'b1, 2'b00, 2, 1, 3};
        tbl[8] = '{0, 4'd9,  1'b1, 1'b0, 2'b11, 2, 1, 3};

        @(negedge clk);
        check("rst_ack", 32'(bus1.booth_ack), 0);
        check("rst_status", 32'(bus1.resp_status), 0);
        check("rst_total", 32'(tot1), 0);
        check("rst_tally", 32'(tc1), 0);
        check("rst_busy", 32'(busy1), 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            vote(0, tbl[i].b, tbl[i].id, tbl[i].c, tbl[i].op, lat, st);
            check($sformatf("v%0d_lat", i), lat, 3);
            check($sformatf("v%0d_status", i), 32'(st), 32'(tbl[i].st));
            sel1 = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_ack_low", i), 32'(bus1.booth_ack), 0);
            check($sformatf("v%0d_st_hold", i),
                  32'(bus1.resp_status), 32'(tbl[i].st));
            check($sformatf("v%0d_tally0", i), 32'(tc1), tbl[i].t0);
            sel1 = 1'b1;
            @(negedge clk);
            check($sformatf("v%0d_tally1", i), 32'(tc1), tbl[i].t1);
            check($sformatf("v%0d_total", i), 32'(tot1), tbl[i].tot);
            check($sformatf("v%0d_idle", i), 32'(busy1), 0);
        end

        // all four booths at once, round-robin from booth 0
        reset_dut();
        @(negedge clk);
        bus1.booth_id   = {4'd5, 4'd4, 4'd2, 4'd1};
        bus1.booth_cand = 4'b1010;
        open1           = 1'b1;
        bus1.booth_req  = 4'b1111;
        n = 0;
        for (int k = 1; k <= 24 && n < 4; k++) begin
            @(negedge clk);
            if (bus1.booth_ack != 4'b0) begin
                who = -1;
                for (int j = 0; j < 4; j++)
                    if (bus1.booth_ack[j]) who = j;
                check($sformatf("rr%0d_booth", n), who, n);
                check($sformatf("rr%0d_time", n), k, 3 + 4*n);
                check($sformatf("rr%0d_status", n),
                      32'(bus1.resp_status), 0);
                if (who >= 0) bus1.booth_req[who] = 1'b0;
                n++;
            end
        end
        check("rr_count", n, 4);
        bus1.booth_req = '0;
        @(negedge clk);
        check("rr_total", 32'(tot1), 4);

        // reset while booth1's vote is in COMMIT
        reset_dut();
        vote(0, 0, 4'd7, 1'b1, 1'b1, lat, st);
        check("ab_pre_status", 32'(st), 0);
        @(negedge clk);
        bus1.booth_id[7:4] = 4'd7;
        bus1.booth_cand[1] = 1'b1;
        bus1.booth_req[1]  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ab_busy_commit", 32'(busy1), 1);
        reset = 1'b1;
        #1;
        check("ab_busy_rst", 32'(busy1), 0);
        check("ab_ack_rst", 32'(bus1.booth_ack), 0);
        check("ab_total_rst", 32'(tot1), 0);
        sel1 = 1'b1;
        @(negedge clk);
        check("ab_ack_hold", 32'(bus1.booth_ack), 0);
        reset = 1'b0;
        lat = -1;
        for (int k = 1; k <= 8 && lat < 0; k++) begin
            @(negedge clk);
            if (bus1.booth_ack != 4'b0) begin
                lat = k;
                check("ab_ack_booth", 32'(bus1.booth_ack), 2);
                check("ab_status", 32'(bus1.resp_status), 0);
                bus1.booth_req[1] = 1'b0;
            end
        end
        check("ab_lat", lat, 3);
        bus1.booth_req = '0;
        @(negedge clk);
        check("ab_tally1", 32'(tc1), 1);
        check("ab_total", 32'(tot1), 1);

        // 2-bit counters: four votes for candidate 0
        reset_dut();
        sel2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vote(1, 0, 4'(i), 1'b0, 1'b1, lat, st);
            check($sformatf("ov%0d_status", i), 32'(st), 0);
            @(negedge clk);
`ifdef TALLY_SATURATE_EN
            exp6 = (i + 1 > 3) ? 3 : i + 1;
`else
            exp6 = (i + 1) % 4;
`endif
            check($sformatf("ov%0d_tally0", i), 32'(tc2), exp6);
            check($sformatf("ov%0d_total", i), 32'(tot2), exp6);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
